reg_file_2r1w: RTL and testbench

- Register file with one synchronous write port and two registered read ports.
- It is the read side that pairs with our single enabled registers: storage is written on one port and consumed by the datapath through two independent read ports.
- Sits between decode (read addresses) and writeback (write address and data) in the processor datapath.
- Read data appears one clock after the read request, matching the pipeline register timing.

---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/reg_file_read_port.sv | 59 +++++
 rtl/reg_file_2r1w.sv | 84 ++++++++
 tb/tb_reg_file_2r1w.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, types and the address acceptance rule for the
// two-read/one-write register file.
//
// Build option: define REG_FILE_BYPASS_EN to forward a same-edge write to a
// read port that is reading the register being written.
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int RF_DEPTH = 16;
  localparam int RF_AW    = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0]  rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;

  // An address names a real, writable register when it is inside the array
  // and is not the hardwired zero register. The same rule decides whether a
  // read returns storage contents or zero.
  function automatic logic rf_addr_valid(input logic [31:0] addr,
                                         input logic        zero_reg,
                                         input int unsigned depth = RF_DEPTH);
    return (addr < depth) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port of the register file.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   re              read enable; rdata holds when low
//   raddr           read address
//   mem_word        storage word currently addressed by raddr
//   wr_en, waddr,   accepted write of this edge (only with REG_FILE_BYPASS_EN)
//   wdata
//   rdata           registered read data, one cycle after the request
//
// Build option: REG_FILE_BYPASS_EN adds write-through forwarding.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter  int N        = DATA_W,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic [N-1:0]  mem_word,
`ifdef REG_FILE_BYPASS_EN
  input  logic          wr_en,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
`endif
  output logic [N-1:0]  rdata
);

  logic         rd_ok;
  logic [N-1:0] rd_word;
  // Power-up value keeps the output at zero before the first reset.
  logic [N-1:0] rdata_p1 = '0;

  // Register 0 (when hardwired) and out-of-range addresses read as zero.
  assign rd_ok = rf_addr_valid(32'(raddr), ZERO_REG != 0, DEPTH);

  always_comb begin
    rd_word = rd_ok ? mem_word : '0;
`ifdef REG_FILE_BYPASS_EN
    // wr_en already excludes discarded writes, so a hit is always a real
    // register and the new value wins over the stale storage word.
    if (wr_en && (waddr == raddr)) rd_word = wdata;
`endif
  end

  // Stage p1: output register, reset has priority over the enable.
  always_ff @(posedge clk) begin
    if (reset)   rdata_p1 <= '0;
    else if (re) rdata_p1 <= rd_word;
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with one synchronous write port and two independent
// registered read ports (1-cycle read latency).
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous active-high reset; clears storage and outputs
//   we, waddr, wdata  write port
//   re_a, raddr_a     read port A request
//   rdata_a           read port A data
//   re_b, raddr_b     read port B request
//   rdata_b           read port B data
//
// Build option: REG_FILE_BYPASS_EN makes a read of the register being written
// on the same edge return the new data instead of the old contents.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter  int N        = DATA_W,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re_a,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b
);

  logic [N-1:0] mem [DEPTH] = '{default: '0};
  logic         wr_ok;
  logic         wr_en;
  logic [N-1:0] word_a;
  logic [N-1:0] word_b;

  assign wr_ok  = rf_addr_valid(32'(waddr), ZERO_REG != 0, DEPTH);
  assign wr_en  = we && wr_ok && !reset;
  assign word_a = mem[raddr_a];
  assign word_b = mem[raddr_b];

  // Storage: reset clears every entry; discarded writes never land.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  reg_file_read_port #(.N(N), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_port_a (
    .clk      (clk),
    .reset    (reset),
    .re       (re_a),
    .raddr    (raddr_a),
    .mem_word (word_a),
`ifdef REG_FILE_BYPASS_EN
    .wr_en    (wr_en),
    .waddr    (waddr),
    .wdata    (wdata),
`endif
    .rdata    (rdata_a)
  );

  reg_file_read_port #(.N(N), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_port_b (
    .clk      (clk),
    .reset    (reset),
    .re       (re_b),
    .raddr    (raddr_b),
    .mem_word (word_b),
`ifdef REG_FILE_BYPASS_EN
    .wr_en    (wr_en),
    .waddr    (waddr),
    .wdata    (wdata),
`endif
    .rdata    (rdata_b)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: two instances (zero register on and off) share
// the same stimulus and are compared against a behavioural model.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re_a = 1'b0;
  logic [3:0]  raddr_a = '0;
  logic        re_b = 1'b0;
  logic [3:0]  raddr_b = '0;
  logic [31:0] rdata_a_z, rdata_b_z, rdata_a_n, rdata_b_n;

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = ZERO_REG=1 build, index 1 = ZERO_REG=0 build.
  logic [31:0] m  [2][16];
  logic [31:0] ea [2];
  logic [31:0] eb [2];

  always #5 clk = ~clk;

  reg_file_2r1w #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a_z),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b_z)
  );

  reg_file_2r1w #(.ZERO_REG(0)) dut_n (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a_n),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b_n)
  );

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic        zr;
      logic        wok;
      logic [31:0] na, nb;
      zr = (k == 0);
      if (reset) begin
        for (int i = 0; i < 16; i++) m[k][i] = '0;
        ea[k] = '0;
        eb[k] = '0;
      end else begin
        wok = we && !(zr && waddr == 4'd0);
        na = ea[k];
        nb = eb[k];
        if (re_a) na = (zr && raddr_a == 4'd0) ? 32'd0 : m[k][raddr_a];
        if (re_b) nb = (zr && raddr_b == 4'd0) ? 32'd0 : m[k][raddr_b];
`ifdef REG_FILE_BYPASS_EN
        if (re_a && wok && raddr_a == waddr) na = wdata;
        if (re_b && wok && raddr_b == waddr) nb = wdata;
`endif
        if (wok) m[k][waddr] = wdata;
        ea[k] = na;
        eb[k] = nb;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a_z"}, rdata_a_z, ea[0]);
    chk({tag, ".b_z"}, rdata_b_z, eb[0]);
    chk({tag, ".a_n"}, rdata_a_n, ea[1]);
    chk({tag, ".b_n"}, rdata_b_n, eb[1]);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    reset = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
  endtask

  initial begin
    logic [31:0] exp7;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m[k][i] = '0;
      ea[k] = '0;
      eb[k] = '0;
    end

    // Power-up, before any reset.
    #1;
    check_all("pwrup");
    cycle("pwrup_idle");

    reset = 1'b1;
    cycle("reset");
    idle();

    // Every address reads zero after reset.
    re_a = 1'b1; re_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i); raddr_b = 4'(15 - i);
      cycle("rd_after_reset");
      chk("rd_after_reset_const", rdata_a_n, 32'd0);
    end
    idle();

    // Preload nonzero values, confirm, then reset clears them.
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      waddr = 4'(i); wdata = 32'h1111_1111 * i + 32'h1;
      cycle("preload");
    end
    idle();
    re_a = 1'b1; re_b = 1'b1; raddr_a = 4'd4; raddr_b = 4'd0;
    cycle("preload_rd");
    chk("preload_r4", rdata_a_n, 32'h4444_4445);
    chk("preload_r0_n", rdata_b_n, 32'h0000_0001);
    chk("preload_r0_z", rdata_b_z, 32'h0);
    idle();
    reset = 1'b1;
    cycle("reset2");
    idle();
    re_a = 1'b1; re_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i); raddr_b = 4'(i);
      cycle("rd_after_reset2");
      chk("cleared_n", rdata_b_n, 32'd0);
    end
    idle();

    // Write r5, read it, then a write with re_a low must not move rdata_a.
    we = 1'b1; waddr = 4'd5; wdata = 32'hDEAD_BEEF;
    cycle("wr_r5");
    idle();
    re_a = 1'b1; raddr_a = 4'd5;
    cycle("rd_r5");
    chk("rd_r5_const", rdata_a_z, 32'hDEAD_BEEF);
    idle();
    we = 1'b1; waddr = 4'd5; wdata = 32'h1;
    cycle("hold_r5");
    chk("hold_r5_const", rdata_a_z, 32'hDEAD_BEEF);
    idle();

    // Register 0 behaviour with and without the zero register.
    we = 1'b1; waddr = 4'd0; wdata = 32'h1234_5678;
    cycle("wr_r0");
    idle();
    re_a = 1'b1; re_b = 1'b1; raddr_a = 4'd0; raddr_b = 4'd0;
    cycle("rd_r0");
    chk("r0_a_z", rdata_a_z, 32'd0);
    chk("r0_b_z", rdata_b_z, 32'd0);
    chk("r0_a_n", rdata_a_n, 32'h1234_5678);
    chk("r0_b_n", rdata_b_n, 32'h1234_5678);
    idle();

    // Same-edge write and read of r7.
    we = 1'b1; waddr = 4'd7; wdata = 32'hAAAA_0000;
    cycle("wr_r7");
    we = 1'b1; waddr = 4'd7; wdata = 32'h0000_5555; re_a = 1'b1; raddr_a = 4'd7;
    cycle("rw_r7");
`ifdef REG_FILE_BYPASS_EN
    exp7 = 32'h0000_5555;
`else
    exp7 = 32'hAAAA_0000;
`endif
    chk("rw_r7_const", rdata_a_z, exp7);
    idle();
    re_a = 1'b1; raddr_a = 4'd7;
    cycle("rd_r7");
    chk("rd_r7_const", rdata_a_z, 32'h0000_5555);
    idle();

    // Port A on r3, port B on r9 while other registers are written.
    we = 1'b1; waddr = 4'd3; wdata = 32'h3333_0003;
    cycle("wr_r3");
    waddr = 4'd9; wdata = 32'h9999_0009;
    cycle("wr_r9");
    re_a = 1'b1; raddr_a = 4'd3; re_b = 1'b1; raddr_b = 4'd9;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      if (wa == 4'd3 || wa == 4'd9) wa = 4'd10;
      waddr = wa; wdata = $urandom;
      cycle("xtalk");
      chk("xtalk_a", rdata_a_z, 32'h3333_0003);
      chk("xtalk_b", rdata_b_z, 32'h9999_0009);
    end
    idle();

    // Reset wins over a same-edge write and read.
    reset = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 32'hFF; re_a = 1'b1; raddr_a = 4'd2;
    cycle("rst_vs_wr");
    chk("rst_vs_wr_a", rdata_a_n, 32'd0);
    idle();
    re_a = 1'b1; raddr_a = 4'd2;
    cycle("rd_r2");
    chk("r2_lost", rdata_a_n, 32'd0);
    idle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 49) == 0);
      we      = $urandom_range(0, 1) == 1;
      waddr   = 4'($urandom_range(0, 15));
      wdata   = $urandom;
      re_a    = $urandom_range(0, 3) != 0;
      re_b    = $urandom_range(0, 3) != 0;
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 4'($urandom_range(0, 15));
      cycle("rand");
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
